// File: rtl/rev_arb_pkg.sv
// Shared types and default widths for the SoC data-memory arbiter.
// Holds the arbiter state encoding, the latched request record and the
// default address/data widths the top level is built around.
package rev_arb_pkg;

   localparam int ARB_AW = 32;
   localparam int ARB_DW = 32;
   localparam int ARB_BW = ARB_DW / 8;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      ISSUE    = 2'd1,
      WAIT_RSP = 2'd2
   } arb_state_e;

   // One captured requester transaction, held for the whole grant.
   typedef struct packed {
      logic [ARB_AW-1:0] addr;
      logic              we;
      logic [ARB_DW-1:0] wdata;
      logic [ARB_BW-1:0] be;
   } arb_req_t;

endpackage : rev_arb_pkg

// File: rtl/rev_rr_picker.sv
// Round-robin selector: first valid requester searching upward from last+1, wrapping.
// Latency: purely combinational, zero cycles.
// Backpressure: none; the caller decides when the pick is consumed.
// Ports: valid_i (request vector), last_i (last granted index),
//        grant_oh_o (one-hot pick), grant_idx_o (binary pick), any_valid_o.
module rev_rr_picker #(
   parameter int N_REQ = 3,
   parameter int IW    = $clog2(N_REQ)
) (
   input  logic [N_REQ-1:0] valid_i,
   input  logic [IW-1:0]    last_i,
   output logic [N_REQ-1:0] grant_oh_o,
   output logic [IW-1:0]    grant_idx_o,
   output logic             any_valid_o
);

   int          cand;
   logic [IW-1:0] cand_idx;
   logic        found;

   always_comb begin
      grant_oh_o  = '0;
      grant_idx_o = '0;
      any_valid_o = |valid_i;
      found       = 1'b0;
      cand        = 0;
      cand_idx    = '0;
      // Offsets 1..N_REQ cover every requester once; offset N_REQ lands on
      // last_i itself, so the previous winner is only picked if alone.
      for (int i = 1; i <= N_REQ; i++) begin
         cand = int'(last_i) + i;
         if (cand >= N_REQ) begin
            cand = cand - N_REQ;
         end
         cand_idx = IW'(cand);
         if (!found && valid_i[cand_idx]) begin
            found       = 1'b1;
            grant_idx_o = cand_idx;
            grant_oh_o  = N_REQ'(1) << cand_idx;
         end
      end
   end

endmodule : rev_rr_picker

// File: rtl/rev_mem_arbiter.sv
// Round-robin arbiter sharing the single data-memory port between N_REQ requesters.
// Latency: 1 cycle req_valid_i -> mem_req_valid_o; rsp_valid_o 1 cycle after mem_rsp_valid_i.
// Backpressure: one transaction in flight; grant held through ISSUE while mem_req_ready_i is low.
// Ports: clk_in1/rst (async active-low), packed per-requester req_* bus with
//        req_ready_o handshake, rsp_valid_o pulse with shared rsp_rdata_o/rsp_err_o,
//        single mem_* request/response port, grant_id_o and busy_o status.
// Optional: define REV_ARB_TIMEOUT_EN to complete a stalled response with an
//           error after TIMEOUT_CYC cycles in WAIT_RSP.
module rev_mem_arbiter
   import rev_arb_pkg::*;
#(
   parameter int N_REQ       = 3,
   parameter int AW          = ARB_AW,
   parameter int DW          = ARB_DW,
   parameter int TIMEOUT_CYC = 255
) (
   input  logic                    clk_in1,
   input  logic                    rst,
   input  logic [N_REQ-1:0]        req_valid_i,
   output logic [N_REQ-1:0]        req_ready_o,
   input  logic [N_REQ*AW-1:0]     req_addr_i,
   input  logic [N_REQ-1:0]        req_we_i,
   input  logic [N_REQ*DW-1:0]     req_wdata_i,
   input  logic [N_REQ*DW/8-1:0]   req_be_i,
   output logic [N_REQ-1:0]        rsp_valid_o,
   output logic [DW-1:0]           rsp_rdata_o,
   output logic                    rsp_err_o,
   output logic                    mem_req_valid_o,
   input  logic                    mem_req_ready_i,
   output logic [AW-1:0]           mem_addr_o,
   output logic                    mem_we_o,
   output logic [DW-1:0]           mem_wdata_o,
   output logic [DW/8-1:0]         mem_be_o,
   input  logic                    mem_rsp_valid_i,
   input  logic [DW-1:0]           mem_rdata_i,
   input  logic                    mem_rsp_err_i,
   output logic [$clog2(N_REQ)-1:0] grant_id_o,
   output logic                    busy_o
);

   localparam int IW = $clog2(N_REQ);
   localparam int BW = DW / 8;

   // The latched request uses the package record, so AW/DW are expected to
   // stay at the package defaults.
   arb_state_e        state_q, state_d;
   logic [IW-1:0]     last_q, last_d;
   logic [IW-1:0]     grant_q, grant_d;
   arb_req_t          req_q, req_d;
   logic [DW-1:0]     rdata_q, rdata_d;
   logic              err_q, err_d;
   logic              pulse_q, pulse_d;

   logic [N_REQ-1:0]  pick_oh;
   logic [IW-1:0]     pick_idx;
   logic              pick_any;
   logic [N_REQ-1:0]  grant_oh;
   logic              issue_acc;

   // Configuration sanity region: legal range is 2..8 requesters and a
   // non-zero response-wait limit.
   if (N_REQ < 2 || N_REQ > 8 || TIMEOUT_CYC < 1) begin : g_cfg_out_of_range
   end

   rev_rr_picker #(
      .N_REQ (N_REQ),
      .IW    (IW)
   ) u_picker (
      .valid_i     (req_valid_i),
      .last_i      (last_q),
      .grant_oh_o  (pick_oh),
      .grant_idx_o (pick_idx),
      .any_valid_o (pick_any)
   );

   assign grant_oh  = N_REQ'(1) << grant_q;
   assign issue_acc = (state_q == ISSUE) && mem_req_ready_i;

`ifdef REV_ARB_TIMEOUT_EN
   localparam int TW = $clog2(TIMEOUT_CYC + 1);

   logic [TW-1:0] to_cnt_q, to_cnt_d;
   logic          to_hit;

   // Counter value k means k full cycles spent in WAIT_RSP; expiring at
   // TIMEOUT_CYC-1 places the error pulse exactly TIMEOUT_CYC cycles after entry.
   assign to_hit = (to_cnt_q == TW'(TIMEOUT_CYC - 1));

   always_comb begin
      to_cnt_d = to_cnt_q;
      if (issue_acc) begin
         to_cnt_d = '0;
      end else if (state_q == WAIT_RSP && !mem_rsp_valid_i) begin
         to_cnt_d = to_cnt_q + TW'(1);
      end
   end

   always_ff @(posedge clk_in1 or negedge rst) begin
      if (!rst) begin
         to_cnt_q <= '0;
      end else begin
         to_cnt_q <= to_cnt_d;
      end
   end
`endif

   always_comb begin
      state_d = state_q;
      last_d  = last_q;
      grant_d = grant_q;
      req_d   = req_q;
      rdata_d = rdata_q;
      err_d   = err_q;
      pulse_d = 1'b0;

      unique case (state_q)
         IDLE: begin
            // Also runs in the cycle the previous response is pulsed.
            if (pick_any) begin
               grant_d     = pick_idx;
               req_d.addr  = req_addr_i[int'(pick_idx)*AW +: AW];
               req_d.we    = req_we_i[pick_idx];
               req_d.wdata = req_wdata_i[int'(pick_idx)*DW +: DW];
               req_d.be    = req_be_i[int'(pick_idx)*BW +: BW];
               state_d     = ISSUE;
            end
         end
         ISSUE: begin
            // A response seen here is stray and deliberately ignored.
            if (mem_req_ready_i) begin
               state_d = WAIT_RSP;
            end
         end
         WAIT_RSP: begin
            if (mem_rsp_valid_i) begin
               rdata_d = mem_rdata_i;
               err_d   = mem_rsp_err_i;
               pulse_d = 1'b1;
               last_d  = grant_q;
               state_d = IDLE;
            end
`ifdef REV_ARB_TIMEOUT_EN
            else if (to_hit) begin
               rdata_d = '0;
               err_d   = 1'b1;
               pulse_d = 1'b1;
               last_d  = grant_q;
               state_d = IDLE;
            end
`endif
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk_in1 or negedge rst) begin
      if (!rst) begin
         state_q <= IDLE;
         last_q  <= IW'(N_REQ - 1);
         grant_q <= '0;
         req_q   <= '0;
         rdata_q <= '0;
         err_q   <= 1'b0;
         pulse_q <= 1'b0;
      end else begin
         state_q <= state_d;
         last_q  <= last_d;
         grant_q <= grant_d;
         req_q   <= req_d;
         rdata_q <= rdata_d;
         err_q   <= err_d;
         pulse_q <= pulse_d;
      end
   end

   assign req_ready_o     = issue_acc ? grant_oh : '0;
   // grant_q is unchanged during the pulse cycle even if re-arbitration fires.
   assign rsp_valid_o     = pulse_q ? grant_oh : '0;
   assign rsp_rdata_o     = rdata_q;
   assign rsp_err_o       = err_q;
   assign mem_req_valid_o = (state_q == ISSUE);
   assign mem_addr_o      = req_q.addr;
   assign mem_we_o        = req_q.we;
   assign mem_wdata_o     = req_q.wdata;
   assign mem_be_o        = req_q.be;
   assign grant_id_o      = grant_q;
   assign busy_o          = (state_q != IDLE);

endmodule : rev_mem_arbiter
